// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC controller.
// The optional FETCH_ALIGN_CHK_EN build adds the align_err output to the top.
package fetch_pc_ctrl_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] RESET_PC_DEF  = 16'h0000;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 16'h0800;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        WAIT_MEM = 3'd1,
        DRAIN    = 3'd2,
        HOLD     = 3'd3,
        HALTED   = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_target_adder.sv
// Redirect target and sequential PC computation; both sums wrap modulo 2^16.
module fetch_target_adder
    import fetch_pc_ctrl_pkg::*;
(
    input  logic              jumprsel,
    input  logic [WORD_W-1:0] id_pc2,
    input  logic [WORD_W-1:0] id_rs,
    input  logic [WORD_W-1:0] id_imm,
    input  logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] target,
    output logic [WORD_W-1:0] pc_plus2
);

    logic [WORD_W-1:0] base;

    assign base     = jumprsel ? id_rs : id_pc2;
    assign target   = base + id_imm;
    assign pc_plus2 = pc + WORD_W'(2);

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage control: PC, instruction-memory handshake and IF/ID register.
// Define FETCH_ALIGN_CHK_EN to add the sticky align_err output for odd redirect targets.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              brjsel,
    input  logic              jumprsel,
    input  logic [WORD_W-1:0] id_pc2,
    input  logic [WORD_W-1:0] id_rs,
    input  logic [WORD_W-1:0] id_imm,
    input  logic              id_halt,
    input  logic              stall,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic              imem_en,
    output logic [WORD_W-1:0] imem_addr,
    output logic [WORD_W-1:0] if_instr,
    output logic [WORD_W-1:0] if_pc2,
    output logic              if_valid,
`ifdef FETCH_ALIGN_CHK_EN
    output logic              align_err,
`endif
    output logic              halted
);

    fetch_state_t      state, state_n;
    logic [WORD_W-1:0] pc, pc_n, redir_pc, redir_n;
    logic [WORD_W-1:0] instr_q, instr_n, pc2_q, pc2_n, hbuf, hbuf_n;
    logic [WORD_W-1:0] tgt_raw, tgt, pc_plus2, drain_dst;
    logic              vld, vld_n;
`ifdef FETCH_ALIGN_CHK_EN
    logic              aerr, aerr_n;
`endif

    fetch_target_adder u_adder (
        .jumprsel (jumprsel),
        .id_pc2   (id_pc2),
        .id_rs    (id_rs),
        .id_imm   (id_imm),
        .pc       (pc),
        .target   (tgt_raw),
        .pc_plus2 (pc_plus2)
    );

`ifdef FETCH_ALIGN_CHK_EN
    assign tgt = tgt_raw;
`else
    assign tgt = tgt_raw & 16'hFFFE;
`endif

    // A redirect arriving while draining replaces the pending target.
    assign drain_dst = brjsel ? tgt : redir_pc;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        redir_n = redir_pc;
        instr_n = instr_q;
        pc2_n   = pc2_q;
        hbuf_n  = hbuf;
        vld_n   = vld;
        imem_en = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        aerr_n  = aerr;
`endif
        case (state)
            RUN: begin
                imem_en = !stall;
                if (brjsel) begin
                    pc_n  = tgt;
                    vld_n = 1'b0;
                end else if (id_halt) begin
                    state_n = HALTED;
                    vld_n   = 1'b0;
                end else if (!stall) begin
                    if (imem_ready) begin
                        instr_n = imem_rdata;
                        pc2_n   = pc_plus2;
                        vld_n   = 1'b1;
                        pc_n    = pc_plus2;
                    end else begin
                        state_n = WAIT_MEM;
                        vld_n   = 1'b0;
                    end
                end
            end
            WAIT_MEM: begin
                imem_en = 1'b1;
                if (brjsel) begin
                    vld_n   = 1'b0;
                    redir_n = tgt;
                    if (imem_ready) begin
                        pc_n    = tgt;
                        state_n = RUN;
                    end else begin
                        state_n = DRAIN;
                    end
                end else if (id_halt) begin
                    state_n = HALTED;
                    vld_n   = 1'b0;
                end else if (imem_ready) begin
                    if (!stall) begin
                        instr_n = imem_rdata;
                        pc2_n   = pc_plus2;
                        vld_n   = 1'b1;
                        pc_n    = pc_plus2;
                        state_n = RUN;
                    end else begin
                        hbuf_n  = imem_rdata;
                        state_n = HOLD;
                    end
                end
            end
            DRAIN: begin
                imem_en = 1'b1;
                vld_n   = 1'b0;
                redir_n = drain_dst;
                if (imem_ready) begin
                    pc_n    = drain_dst;
                    state_n = RUN;
                end
            end
            HOLD: begin
                if (brjsel) begin
                    pc_n    = tgt;
                    vld_n   = 1'b0;
                    state_n = RUN;
                end else if (id_halt) begin
                    state_n = HALTED;
                    vld_n   = 1'b0;
                end else if (!stall) begin
                    instr_n = hbuf;
                    pc2_n   = pc_plus2;
                    vld_n   = 1'b1;
                    pc_n    = pc_plus2;
                    state_n = RUN;
                end
            end
            HALTED:  vld_n = 1'b0;
            default: state_n = RUN;
        endcase
`ifdef FETCH_ALIGN_CHK_EN
        // An odd target never gets fetched: stop the core and flag it.
        if (brjsel && tgt_raw[0] && state != HALTED) begin
            state_n = HALTED;
            pc_n    = pc;
            vld_n   = 1'b0;
            aerr_n  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            redir_pc <= '0;
            instr_q  <= NOP_INSTR;
            pc2_q    <= '0;
            hbuf     <= '0;
            vld      <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            aerr     <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            redir_pc <= redir_n;
            instr_q  <= instr_n;
            pc2_q    <= pc2_n;
            hbuf     <= hbuf_n;
            vld      <= vld_n;
`ifdef FETCH_ALIGN_CHK_EN
            aerr     <= aerr_n;
`endif
        end
    end

    assign imem_addr = pc;
    assign if_instr  = vld ? instr_q : NOP_INSTR;
    assign if_pc2    = pc2_q;
    assign if_valid  = vld;
    assign halted    = (state == HALTED);
`ifdef FETCH_ALIGN_CHK_EN
    assign align_err = aerr;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Table-driven bench for fetch_pc_ctrl; each row's expectations go through a scoreboard queue.
// Memory model returns addr+0x1000 so fetched words are easy to trace by hand.
module tb_fetch_pc_ctrl;

    // ctl = {rst_n, imem_ready, stall, brjsel, jumprsel, id_halt}
    // ef  = {check, imem_en, if_valid, halted, align_err, check_if_pc2}
    typedef struct {
        logic [5:0]  ctl;
        logic [15:0] pc2, rs, imm;
        logic [5:0]  ef;
        logic [15:0] e_addr, e_instr, e_pc2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, brjsel = 1'b0, jumprsel = 1'b0, id_halt = 1'b0;
    logic        stall = 1'b0, imem_ready = 1'b0;
    logic [15:0] id_pc2 = '0, id_rs = '0, id_imm = '0;
    logic [15:0] imem_rdata, imem_addr, if_instr, if_pc2;
    logic        imem_en, if_valid, halted;
`ifdef FETCH_ALIGN_CHK_EN
    logic        align_err;
`endif

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];
    vec_t tblb[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr + 16'h1000;

    fetch_pc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .brjsel     (brjsel),
        .jumprsel   (jumprsel),
        .id_pc2     (id_pc2),
        .id_rs      (id_rs),
        .id_imm     (id_imm),
        .id_halt    (id_halt),
        .stall      (stall),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .if_instr   (if_instr),
        .if_pc2     (if_pc2),
        .if_valid   (if_valid),
`ifdef FETCH_ALIGN_CHK_EN
        .align_err  (align_err),
`endif
        .halted     (halted)
    );

    function automatic vec_t mk(logic [5:0] ctl, logic [15:0] pc2, logic [15:0] rs,
                                logic [15:0] imm, logic [5:0] ef, logic [15:0] ea,
                                logic [15:0] ei, logic [15:0] ep);
        vec_t v;
        v.ctl = ctl; v.pc2 = pc2; v.rs = rs; v.imm = imm;
        v.ef = ef; v.e_addr = ea; v.e_instr = ei; v.e_pc2 = ep;
        return v;
    endfunction

    task automatic cmp(string nm, int row, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then check the pre-edge outputs against the queued row.
    task automatic apply(vec_t v, int row);
        vec_t e;
        @(negedge clk);
        {rst_n, imem_ready, stall, brjsel, jumprsel, id_halt} = v.ctl;
        id_pc2 = v.pc2;
        id_rs  = v.rs;
        id_imm = v.imm;
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        if (e.ef[5]) begin
            cmp("imem_en", row, {15'b0, imem_en}, {15'b0, e.ef[4]});
            if (e.ef[4]) cmp("imem_addr", row, imem_addr, e.e_addr);
            cmp("if_valid", row, {15'b0, if_valid}, {15'b0, e.ef[3]});
            cmp("if_instr", row, if_instr, e.e_instr);
            if (e.ef[0]) cmp("if_pc2", row, if_pc2, e.e_pc2);
            cmp("halted", row, {15'b0, halted}, {15'b0, e.ef[2]});
`ifdef FETCH_ALIGN_CHK_EN
            cmp("align_err", row, {15'b0, align_err}, {15'b0, e.ef[1]});
`endif
        end
    endtask

    initial begin
        // reset release and streaming, then PC-relative and register redirects
        tbl.push_back(mk(6'b010000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b110001, 16'h0000, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b111001, 16'h0002, 16'h1000, 16'h0002));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b111001, 16'h0004, 16'h1002, 16'h0004));
        tbl.push_back(mk(6'b110100, 16'h0010, 16'h0000, 16'hFFF8, 6'b111001, 16'h0006, 16'h1004, 16'h0006));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b110000, 16'h0008, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b110110, 16'h0000, 16'hFFFE, 16'h0004, 6'b111001, 16'h000A, 16'h1008, 16'h000A));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b110000, 16'h0002, 16'h0800, 16'h0000));
        // odd register target: halts with align_err, or silently clears bit0
        tbl.push_back(mk(6'b110110, 16'h0000, 16'h0021, 16'h0000, 6'b111001, 16'h0004, 16'h1002, 16'h0004));
`ifdef FETCH_ALIGN_CHK_EN
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b100110, 16'h0000, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b010000, 16'h0000, 16'h0000, 16'h0000, 6'b100110, 16'h0000, 16'h0800, 16'h0000));
`else
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b110000, 16'h0020, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b010000, 16'h0000, 16'h0000, 16'h0000, 6'b111001, 16'h0022, 16'h1020, 16'h0022));
`endif
        // ready low 3 cycles, redirect to 0040 on the second: drain then refetch
        tbl.push_back(mk(6'b100000, 16'h0000, 16'h0000, 16'h0000, 6'b110001, 16'h0000, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b100100, 16'h0040, 16'h0000, 16'h0000, 6'b110000, 16'h0000, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b100000, 16'h0000, 16'h0000, 16'h0000, 6'b110000, 16'h0000, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b110000, 16'h0000, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b110000, 16'h0040, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b111001, 16'h0042, 16'h1040, 16'h0042));
        // response arrives under a 2-cycle stall: held, delivered once after stall drops
        tbl.push_back(mk(6'b100000, 16'h0000, 16'h0000, 16'h0000, 6'b111001, 16'h0044, 16'h1042, 16'h0044));
        tbl.push_back(mk(6'b111000, 16'h0000, 16'h0000, 16'h0000, 6'b110000, 16'h0044, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b111000, 16'h0000, 16'h0000, 16'h0000, 6'b100000, 16'h0000, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b100000, 16'h0000, 16'h0000, 16'h0000, 6'b100000, 16'h0000, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b111001, 16'h0046, 16'h1044, 16'h0046));
        // plain RUN stall holds IF/ID and the PC
        tbl.push_back(mk(6'b111000, 16'h0000, 16'h0000, 16'h0000, 6'b101001, 16'h0000, 16'h1046, 16'h0048));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b111001, 16'h0048, 16'h1046, 16'h0048));
        // redirect while holding a buffered word drops it
        tbl.push_back(mk(6'b100000, 16'h0000, 16'h0000, 16'h0000, 6'b111001, 16'h004A, 16'h1048, 16'h004A));
        tbl.push_back(mk(6'b111000, 16'h0000, 16'h0000, 16'h0000, 6'b110000, 16'h004A, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b101100, 16'h0100, 16'h0000, 16'h0010, 6'b100000, 16'h0000, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b110000, 16'h0110, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b111001, 16'h0112, 16'h1110, 16'h0112));
        // redirect in WAIT_MEM with ready the same cycle goes straight to the target
        tbl.push_back(mk(6'b100000, 16'h0000, 16'h0000, 16'h0000, 6'b111001, 16'h0114, 16'h1112, 16'h0114));
        tbl.push_back(mk(6'b110100, 16'h0200, 16'h0000, 16'h0000, 6'b110000, 16'h0114, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b110000, 16'h0200, 16'h0800, 16'h0000));
        // halt, and a redirect that must be ignored once halted
        tbl.push_back(mk(6'b110001, 16'h0000, 16'h0000, 16'h0000, 6'b111001, 16'h0202, 16'h1200, 16'h0202));
        tbl.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b100100, 16'h0000, 16'h0800, 16'h0000));
        tbl.push_back(mk(6'b110100, 16'h0300, 16'h0000, 16'h0000, 6'b100100, 16'h0000, 16'h0800, 16'h0000));

        // one reset cycle out of HALTED, then a redirect to FFFE whose pc+2 wraps
        tblb.push_back(mk(6'b010000, 16'h0000, 16'h0000, 16'h0000, 6'b100100, 16'h0000, 16'h0800, 16'h0000));
        tblb.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b110001, 16'h0000, 16'h0800, 16'h0000));
        tblb.push_back(mk(6'b110100, 16'hFFF0, 16'h0000, 16'h000E, 6'b111001, 16'h0002, 16'h1000, 16'h0002));
        tblb.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b110000, 16'hFFFE, 16'h0800, 16'h0000));
        tblb.push_back(mk(6'b110000, 16'h0000, 16'h0000, 16'h0000, 6'b111001, 16'h0000, 16'h0FFE, 16'h0000));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // halted must ignore everything except reset
        for (int k = 0; k < 20; k++) begin
            logic [5:0] c;
            c = {1'b1, 5'($urandom)};
            apply(mk(c, 16'($urandom), 16'($urandom), 16'($urandom), 6'b100100,
                     16'h0000, 16'h0800, 16'h0000), 100 + k);
        end

        for (int i = 0; i < tblb.size(); i++) apply(tblb[i], 200 + i);

        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: got %0d leftover want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
